ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: fetch PC register feeding a 2-entry {pc, instr} queue to decode.
// Optional misaligned-redirect trap is enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic [AWIDTH-1:0] imem_pc,
    input  logic [DWIDTH-1:0] imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_instr,
    output logic [AWIDTH-1:0] out_pc,
    output logic              misalign_err
);

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    entry_t            ent [2];
    logic              wptr;
    logic              rptr;
    logic              valid_q;
    logic              halted;
    logic              err_q;
    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] target;
    logic              target_bad;
    logic              pop;
    logic              push;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
`else
    // Low bits are dropped so a stray misaligned target still fetches the enclosing word.
    assign target     = redirect_pc & ~AWIDTH'(3);
    assign target_bad = 1'b0;
`endif

    assign pop  = valid_q & out_ready;
    assign push = ~redirect_valid & ~halted & ((state != FULL) | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            valid_q  <= 1'b0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            halted   <= 1'b0;
            err_q    <= 1'b0;
            fetch_pc <= RESET_PC;
            ent[0]   <= '0;
            ent[1]   <= '0;
        end else if (redirect_valid) begin
            // Flush wins over everything; a same-cycle pop has already been consumed by decode.
            state   <= EMPTY;
            valid_q <= 1'b0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            if (target_bad) begin
                halted <= 1'b1;
                err_q  <= 1'b1;
            end else begin
                halted   <= 1'b0;
                err_q    <= 1'b0;
                fetch_pc <= target;
            end
        end else begin
            if (push) begin
                ent[wptr] <= '{pc: fetch_pc, instr: imem_instr};
                wptr      <= ~wptr;
                fetch_pc  <= fetch_pc + AWIDTH'(4);
            end
            if (pop)
                rptr <= ~rptr;
            case (state)
                EMPTY: begin
                    if (push) begin
                        state   <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state <= FULL;
                    end else if (pop && !push) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop && !push)
                        state <= ONE;
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_pc      = fetch_pc;
    assign out_valid    = valid_q;
    assign out_pc       = ent[rptr].pc;
    assign out_instr    = ent[rptr].instr;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, streaming, backpressure, redirect, wrap, misalign, async reset.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int n_chk  = 0;
    int n_fail = 0;

    ifetch_queue #(.AWIDTH(32), .DWIDTH(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    // Instruction memory image: fixed word at 0, an address-derived pattern elsewhere.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0041e5b3 : {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hbeef};
    endfunction

    assign imem_instr = word_at(imem_pc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 64'(out_valid), 64'h1);
        check({tag, ".pc"},    64'(out_pc),    64'(pc));
        check({tag, ".instr"}, 64'(out_instr), 64'(word_at(pc)));
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        step();
        step();
        check("rst.valid",  64'(out_valid),    64'h0);
        check("rst.pc",     64'(out_pc),       64'h0);
        check("rst.instr",  64'(out_instr),    64'h0);
        check("rst.err",    64'(misalign_err), 64'h0);
        check("rst.imempc", 64'(imem_pc),      64'h0);

        // Streaming with decode always ready
        rst = 1'b0;
        step();
        check("stream.instr0", 64'(out_instr), 64'h0041e5b3);
        expect_head("stream0", 32'h0);
        step();
        expect_head("stream1", 32'h4);
        step();
        expect_head("stream2", 32'h8);

        // Backpressure: fill to two entries then drain with no gaps
        rst       = 1'b1;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        step();
        expect_head("bp.first", 32'h0);
        for (int i = 0; i < 4; i++) step();
        expect_head("bp.hold", 32'h0);
        check("bp.imempc", 64'(imem_pc), 64'h8);
        out_ready = 1'b1;
        step();
        expect_head("bp.drain1", 32'h4);
        step();
        expect_head("bp.drain2", 32'h8);
        step();
        expect_head("bp.drain3", 32'hC);

        // Redirect while FULL
        out_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h88;
        step();
        redirect_valid = 1'b0;
        check("redir.valid",  64'(out_valid), 64'h0);
        check("redir.imempc", 64'(imem_pc),   64'h88);
        step();
        expect_head("redir.first", 32'h88);
        out_ready = 1'b1;

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap.imempc", 64'(imem_pc), 64'hFFFF_FFFC);
        step();
        expect_head("wrap.top", 32'hFFFF_FFFC);
        step();
        expect_head("wrap.zero", 32'h0);
        check("wrap.imempc2", 64'(imem_pc), 64'h4);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h86;
        step();
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("mis.err",    64'(misalign_err), 64'h1);
        check("mis.imempc", 64'(imem_pc),      64'h4);
        for (int i = 0; i < 3; i++) step();
        check("mis.valid", 64'(out_valid),    64'h0);
        check("mis.err2",  64'(misalign_err), 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("mis.clr", 64'(misalign_err), 64'h0);
        step();
        expect_head("mis.resume", 32'h40);
`else
        check("mis.err",    64'(misalign_err), 64'h0);
        check("mis.imempc", 64'(imem_pc),      64'h84);
        step();
        expect_head("mis.forced", 32'h84);
`endif

        // Asynchronous reset mid-cycle while FULL
        out_ready = 1'b0;
        step();
        step();
        check("arst.full", 64'(out_valid), 64'h1);
        #3;
        rst = 1'b1;
        #1;
        check("arst.valid",  64'(out_valid), 64'h0);
        check("arst.pc",     64'(out_pc),    64'h0);
        check("arst.imempc", 64'(imem_pc),   64'h0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        expect_head("arst.restart", 32'h0);
        step();
        expect_head("arst.next", 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
